if_stage: RTL and testbench

// - Instruction-fetch stage of the 5-stage predicated pipeline; directly upstream of ID_stage.
// - Holds the PC, reads word-addressed instruction memory and selects the next PC from the

---
 rtl/if_stage.sv | 134 +++++++++++++
 tb/tb_if_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
//
// Instruction-fetch stage of the 5-stage predicated pipeline, directly upstream
// of ID_stage. Holds the fetch PC, reads the word-addressed instruction memory
// combinationally and loads the IF/ID register. The next PC is chosen from the
// redirect sources resolved in ID: an absolute jump/call target, a
// register-indirect target, or sequential PC+1.
//
// Parameters
//   RESET_PC   PC value loaded on reset
//   IMEM_AW    instruction-memory address width (depth = 2**IMEM_AW words)
//   IMEM_FILE  instruction-memory image name (memory is loaded by the environment)
//   NOP_INSTR  bubble encoding loaded into IF/ID on KILL and reset
//
// Ports
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   PCsrc          in   2   next-PC select: 00 PC+1, 01 PC_offset, 10 PC_regRs, 11 PC+1
//   KILL           in   1   squash the instruction fetched this cycle
//   PC_offset      in   32  absolute jump/call target
//   PC_regRs       in   32  register-indirect target (JR/RET)
//   disable_PC     in   1   hold PC (load-use stall)
//   disable_IR     in   1   hold IF/ID register (load-use stall)
//   Instruction_D  out  32  IF/ID instruction
//   NPC_D          out  32  IF/ID next PC (fetch PC + 1)
//   Valid_D        out  1   1 = real fetched instruction, 0 = bubble
//   PC_F           out  32  current fetch PC
//   Fetch_cnt      out  32  valid IF/ID loads      (only with IF_PERF_CNT_EN)
//   Kill_cnt       out  32  KILL bubbles loaded    (only with IF_PERF_CNT_EN)
//
// Configuration
//   IF_PERF_CNT_EN  defined: adds the Fetch_cnt / Kill_cnt performance counters.
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          IMEM_AW   = 10,
    parameter string       IMEM_FILE = "imem.hex",
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  PCsrc,
    input  logic        KILL,
    input  logic [31:0] PC_offset,
    input  logic [31:0] PC_regRs,
    input  logic        disable_PC,
    input  logic        disable_IR,
    output logic [31:0] Instruction_D,
    output logic [31:0] NPC_D,
    output logic        Valid_D,
    output logic [31:0] PC_F
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] Fetch_cnt,
    output logic [31:0] Kill_cnt
`endif
);

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_JMP = 2'b01,
        PC_REG = 2'b10,
        PC_RSV = 2'b11
    } pcsrc_e;

    // NOTE: the instruction memory is a ROM image and is deliberately not
    // reset; only the PC and the IF/ID register carry reset values.
    logic [31:0] imem [0:(1 << IMEM_AW) - 1];

    logic [31:0] instr_f;
    logic [31:0] pc_plus1;
    logic [31:0] pc_next;

    // Upper PC bits are ignored, so fetch addresses wrap on the memory depth.
    assign instr_f  = imem[PC_F[IMEM_AW-1:0]];
    assign pc_plus1 = PC_F + 32'd1;   // modular, no carry out

    // NOTE: pc_next gets its default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        pc_next = pc_plus1;
        case (pcsrc_e'(PCsrc))
            PC_JMP:  pc_next = PC_offset;
            PC_REG:  pc_next = PC_regRs;
            default: pc_next = pc_plus1;   // PC_SEQ and reserved PC_RSV
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC_F <= RESET_PC;
        end else if (!disable_PC) begin
            PC_F <= pc_next;
        end
    end

    // IF/ID register. A stall outranks KILL: the squash is re-issued by ID
    // once the stall lifts, so dropping it here loses nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Instruction_D <= NOP_INSTR;
            NPC_D         <= RESET_PC;
            Valid_D       <= 1'b0;
        end else if (!disable_IR) begin
            NPC_D <= pc_plus1;
            if (KILL) begin
                Instruction_D <= NOP_INSTR;
                Valid_D       <= 1'b0;
            end else begin
                Instruction_D <= instr_f;
                Valid_D       <= 1'b1;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Fetch_cnt <= 32'd0;
            Kill_cnt  <= 32'd0;
        end else if (!disable_IR) begin
            if (KILL) begin
                Kill_cnt <= Kill_cnt + 32'd1;
            end else begin
                Fetch_cnt <= Fetch_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
//
// Directed self-checking bench for if_stage. The instruction memory is
// preloaded with a known pattern (imem[0] = 32'h0185_1100, otherwise
// 32'hC0DE_0000 | address); expected values are computed from that pattern
// and from hand-derived PC sequences. Works with and without IF_PERF_CNT_EN.
// -----------------------------------------------------------------------------
module tb_if_stage;

    localparam int          AW  = 10;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  PCsrc;
    logic        KILL;
    logic [31:0] PC_offset;
    logic [31:0] PC_regRs;
    logic        disable_PC;
    logic        disable_IR;
    logic [31:0] Instruction_D;
    logic [31:0] NPC_D;
    logic        Valid_D;
    logic [31:0] PC_F;
`ifdef IF_PERF_CNT_EN
    logic [31:0] Fetch_cnt;
    logic [31:0] Kill_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC (32'd0),
        .IMEM_AW  (AW),
        .IMEM_FILE(""),
        .NOP_INSTR(NOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PCsrc        (PCsrc),
        .KILL         (KILL),
        .PC_offset    (PC_offset),
        .PC_regRs     (PC_regRs),
        .disable_PC   (disable_PC),
        .disable_IR   (disable_IR),
        .Instruction_D(Instruction_D),
        .NPC_D        (NPC_D),
        .Valid_D      (Valid_D),
        .PC_F         (PC_F)
`ifdef IF_PERF_CNT_EN
        ,
        .Fetch_cnt    (Fetch_cnt),
        .Kill_cnt     (Kill_cnt)
`endif
    );

    function automatic logic [31:0] imem_word(input int a);
        return (a == 0) ? 32'h0185_1100 : (32'hC0DE_0000 | 32'(a));
    endfunction

    // One clock edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        PCsrc      = 2'b00;
        KILL       = 1'b0;
        PC_offset  = 32'd0;
        PC_regRs   = 32'd0;
        disable_PC = 1'b0;
        disable_IR = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #3;
        checks++; if (PC_F !== 32'd0) begin failures++; $display("FAIL reset_pc: got %h want %h", PC_F, 32'd0); end
        checks++; if (Instruction_D !== NOP) begin failures++; $display("FAIL reset_instr: got %h want %h", Instruction_D, NOP); end
        checks++; if (NPC_D !== 32'd0) begin failures++; $display("FAIL reset_npc: got %h want %h", NPC_D, 32'd0); end
        checks++; if (Valid_D !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want %b", Valid_D, 1'b0); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (Instruction_D !== 32'h0185_1100) begin failures++; $display("FAIL t1_instr: got %h want %h", Instruction_D, 32'h0185_1100); end
        checks++; if (NPC_D !== 32'd1) begin failures++; $display("FAIL t1_npc: got %h want %h", NPC_D, 32'd1); end
        checks++; if (PC_F !== 32'd1) begin failures++; $display("FAIL t1_pc: got %h want %h", PC_F, 32'd1); end
        checks++; if (Valid_D !== 1'b1) begin failures++; $display("FAIL t1_valid: got %b want %b", Valid_D, 1'b1); end
    endtask

    // Edges 2..4 of the sequential run (edge 1 is covered by test_reset).
    task automatic test_sequential();
        for (int k = 2; k <= 4; k++) begin
            tick();
            checks++; if (NPC_D !== 32'(k)) begin failures++; $display("FAIL seq_npc[%0d]: got %h want %h", k, NPC_D, 32'(k)); end
            checks++; if (Instruction_D !== imem_word(k - 1)) begin failures++; $display("FAIL seq_instr[%0d]: got %h want %h", k, Instruction_D, imem_word(k - 1)); end
            checks++; if (Valid_D !== 1'b1) begin failures++; $display("FAIL seq_valid[%0d]: got %b want %b", k, Valid_D, 1'b1); end
        end
        tick();   // PC_F 4 -> 5, fetches imem[4]
        checks++; if (PC_F !== 32'd5) begin failures++; $display("FAIL seq_pc5: got %h want %h", PC_F, 32'd5); end
    endtask

    task automatic test_jump();
        PCsrc = 2'b01; PC_offset = 32'd40; KILL = 1'b1;
        tick();
        checks++; if (Instruction_D !== NOP) begin failures++; $display("FAIL jmp_bubble_instr: got %h want %h", Instruction_D, NOP); end
        checks++; if (Valid_D !== 1'b0) begin failures++; $display("FAIL jmp_bubble_valid: got %b want %b", Valid_D, 1'b0); end
        checks++; if (NPC_D !== 32'd6) begin failures++; $display("FAIL jmp_bubble_npc: got %h want %h", NPC_D, 32'd6); end
        checks++; if (PC_F !== 32'd40) begin failures++; $display("FAIL jmp_pc: got %h want %h", PC_F, 32'd40); end
        idle_inputs();
        tick();
        checks++; if (Instruction_D !== imem_word(40)) begin failures++; $display("FAIL jmp_target_instr: got %h want %h", Instruction_D, imem_word(40)); end
        checks++; if (NPC_D !== 32'd41) begin failures++; $display("FAIL jmp_target_npc: got %h want %h", NPC_D, 32'd41); end
`ifdef IF_PERF_CNT_EN
        checks++; if (Fetch_cnt !== 32'd6) begin failures++; $display("FAIL fetch_cnt: got %0d want %0d", Fetch_cnt, 6); end
        checks++; if (Kill_cnt !== 32'd1) begin failures++; $display("FAIL kill_cnt: got %0d want %0d", Kill_cnt, 1); end
`endif
    endtask

    task automatic test_jr();
        // PC_F = 41 here.
        PCsrc = 2'b10; PC_regRs = 32'h0000_0123; PC_offset = 32'd77; KILL = 1'b1;
        tick();
        checks++; if (PC_F !== 32'h0000_0123) begin failures++; $display("FAIL jr_pc: got %h want %h", PC_F, 32'h123); end
        checks++; if (NPC_D !== 32'd42) begin failures++; $display("FAIL jr_bubble_npc: got %h want %h", NPC_D, 32'd42); end
        idle_inputs();
        tick();
        checks++; if (Instruction_D !== imem_word(32'h123)) begin failures++; $display("FAIL jr_instr: got %h want %h", Instruction_D, imem_word(32'h123)); end
        checks++; if (NPC_D !== 32'h0000_0124) begin failures++; $display("FAIL jr_npc: got %h want %h", NPC_D, 32'h124); end
        // Address above the memory depth aliases onto imem[0x123].
        PCsrc = 2'b10; PC_regRs = 32'h0000_0523; KILL = 1'b1;
        tick();
        idle_inputs();
        tick();
        checks++; if (Instruction_D !== imem_word(32'h123)) begin failures++; $display("FAIL wrap_addr_instr: got %h want %h", Instruction_D, imem_word(32'h123)); end
        checks++; if (NPC_D !== 32'h0000_0524) begin failures++; $display("FAIL wrap_addr_npc: got %h want %h", NPC_D, 32'h524); end
        // PC+1 wraps from all-ones to zero.
        PCsrc = 2'b01; PC_offset = 32'hFFFF_FFFF; KILL = 1'b1;
        tick();
        idle_inputs();
        tick();
        checks++; if (Instruction_D !== imem_word(1023)) begin failures++; $display("FAIL pc_wrap_instr: got %h want %h", Instruction_D, imem_word(1023)); end
        checks++; if (NPC_D !== 32'd0) begin failures++; $display("FAIL pc_wrap_npc: got %h want %h", NPC_D, 32'd0); end
        checks++; if (PC_F !== 32'd0) begin failures++; $display("FAIL pc_wrap_pc: got %h want %h", PC_F, 32'd0); end
        // Reserved select behaves as PC+1.
        PCsrc = 2'b11; PC_offset = 32'd500; PC_regRs = 32'd600;
        tick();
        checks++; if (PC_F !== 32'd1) begin failures++; $display("FAIL pcsrc11_pc: got %h want %h", PC_F, 32'd1); end
        checks++; if (Instruction_D !== imem_word(0)) begin failures++; $display("FAIL pcsrc11_instr: got %h want %h", Instruction_D, imem_word(0)); end
        idle_inputs();
    endtask

    task automatic test_stall();
        PCsrc = 2'b01; PC_offset = 32'd6; KILL = 1'b1;
        tick();
        idle_inputs();
        tick();   // fetch imem[6], PC_F -> 7
        checks++; if (PC_F !== 32'd7) begin failures++; $display("FAIL stall_setup_pc: got %h want %h", PC_F, 32'd7); end
        disable_PC = 1'b1; disable_IR = 1'b1; KILL = 1'b1; PCsrc = 2'b01; PC_offset = 32'd99;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (PC_F !== 32'd7) begin failures++; $display("FAIL stall_pc[%0d]: got %h want %h", c, PC_F, 32'd7); end
            checks++; if (Instruction_D !== imem_word(6)) begin failures++; $display("FAIL stall_instr[%0d]: got %h want %h", c, Instruction_D, imem_word(6)); end
            checks++; if (NPC_D !== 32'd7) begin failures++; $display("FAIL stall_npc[%0d]: got %h want %h", c, NPC_D, 32'd7); end
            checks++; if (Valid_D !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d]: got %b want %b", c, Valid_D, 1'b1); end
        end
        idle_inputs();
        tick();
        checks++; if (Instruction_D !== imem_word(7)) begin failures++; $display("FAIL stall_release_instr: got %h want %h", Instruction_D, imem_word(7)); end
        checks++; if (NPC_D !== 32'd8) begin failures++; $display("FAIL stall_release_npc: got %h want %h", NPC_D, 32'd8); end
        checks++; if (PC_F !== 32'd8) begin failures++; $display("FAIL stall_release_pc: got %h want %h", PC_F, 32'd8); end
    endtask

    task automatic test_async_reset();
        tick();   // PC_F 8 -> 9
        checks++; if (PC_F !== 32'd9) begin failures++; $display("FAIL areset_setup_pc: got %h want %h", PC_F, 32'd9); end
        #2;
        rst_n = 1'b0;
        #1;       // still well before the next edge
        checks++; if (PC_F !== 32'd0) begin failures++; $display("FAIL areset_pc: got %h want %h", PC_F, 32'd0); end
        checks++; if (Instruction_D !== NOP) begin failures++; $display("FAIL areset_instr: got %h want %h", Instruction_D, NOP); end
        checks++; if (NPC_D !== 32'd0) begin failures++; $display("FAIL areset_npc: got %h want %h", NPC_D, 32'd0); end
        checks++; if (Valid_D !== 1'b0) begin failures++; $display("FAIL areset_valid: got %b want %b", Valid_D, 1'b0); end
`ifdef IF_PERF_CNT_EN
        checks++; if (Fetch_cnt !== 32'd0) begin failures++; $display("FAIL areset_fetch_cnt: got %0d want %0d", Fetch_cnt, 0); end
        checks++; if (Kill_cnt !== 32'd0) begin failures++; $display("FAIL areset_kill_cnt: got %0d want %0d", Kill_cnt, 0); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (Instruction_D !== imem_word(0)) begin failures++; $display("FAIL areset_refetch_instr: got %h want %h", Instruction_D, imem_word(0)); end
        checks++; if (PC_F !== 32'd1) begin failures++; $display("FAIL areset_refetch_pc: got %h want %h", PC_F, 32'd1); end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            dut.imem[i] = imem_word(i);
        end
        test_reset();
        test_sequential();
        test_jump();
        test_jr();
        test_stall();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
